// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed memory with programmable wait
// states, a small response FIFO, flush for branch redirects and a boot load port.
module imem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int PW    = $clog2(RSP_DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [PW:0]      FULL_CNT = (PW + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             push;
  logic             pop;

  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      fifo_data_q [RSP_DEPTH];
  logic             fifo_err_q  [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  logic             req_err;
  logic [31:0]      push_data;
  logic             ld_in_range;
  logic             unused_ld_lsbs;

  assign unused_ld_lsbs = ^ld_addr[1:0];

  // Checks run on the latched address; the memory read is combinational so the
  // pushed word is whatever the array held before a same-edge load.
  assign req_err   = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(MEM_WORDS));
  assign push_data = req_err ? NOP : mem[addr_q[AW+1:2]];

  assign ld_in_range = {2'b00, ld_addr[31:2]} < 32'(MEM_WORDS);

  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : NOP;
  assign rsp_err   = rsp_valid && fifo_err_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready && !flush;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    push      = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = resetn && !flush && (count_q != FULL_CNT);
        if (req_valid && req_ready) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          addr_d  = req_addr;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; validity lives in count_q, and the
  // instruction memory must survive reset anyway.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) mem[ld_addr[AW+1:2]] <= ld_data;
  end

endmodule
